adder_result_fifo: RTL

- Downstream buffer stage for the 4-bit adder datapath.
- Captures each {carry, sum} result the adder produces and holds it in a small first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Decouples the adder from a slower consumer such as a display or serial output stage.
- Flags any result that arrives while the FIFO is full.

---
 rtl/adder_result_fifo.sv | 83 ++++++++
 1 files changed

// File: rtl/adder_result_fifo.sv
// First-word-fall-through result FIFO behind the 4-bit adder, with a sticky overflow flag.
// Optional pop accumulator is enabled by defining ADDER_RESULT_FIFO_ACCUM_EN.
module adder_result_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic                      inValid,
  input  logic [DATA_W-1:0]         inSum,
  input  logic                      inCarry,
  output logic                      inReady,
  output logic                      outValid,
  output logic [DATA_W-1:0]         outSum,
  output logic                      outCarry,
  input  logic                      outReady,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      ovf,
  input  logic                      ovfClr
`ifdef ADDER_RESULT_FIFO_ACCUM_EN
  ,
  input  logic                      accClr,
  output logic [DATA_W+2:0]         accOut
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic              carry;
    logic [DATA_W-1:0] sum;
  } entry_t;

  entry_t [DEPTH-1:0] mem;
  entry_t             head;
  logic [PW-1:0]      wrPtr, rdPtr;
  logic               push, pop;

  // Full refuses a push even if a pop lands in the same cycle, so inReady
  // never depends on outReady.
  assign inReady  = (count != CW'(DEPTH));
  assign outValid = (count != '0);
  assign push     = inValid & inReady;
  assign pop      = outValid & outReady;
  assign head     = mem[rdPtr];
  assign outSum   = head.sum;
  assign outCarry = head.carry;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mem   <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) begin
        mem[wrPtr] <= '{carry: inCarry, sum: inSum};
        wrPtr      <= wrPtr + PW'(1);
      end
      if (pop) rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Set wins over clear.
      if (inValid & ~inReady) ovf <= 1'b1;
      else if (ovfClr)        ovf <= 1'b0;
    end
  end

`ifdef ADDER_RESULT_FIFO_ACCUM_EN
  logic [DATA_W+2:0] popVal;
  assign popVal = (DATA_W+3)'(head);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)       accOut <= '0;
    else if (pop)    accOut <= accClr ? popVal : accOut + popVal;
    else if (accClr) accOut <= '0;
  end
`endif
endmodule
